// File: rtl/spi_pkg.sv
// Shared defaults and state encoding for the SPI frame transmitter.
package spi_pkg;

  localparam int          CLK_DIV_DEF         = 112;
  localparam int          WORD_W_DEF          = 16;
  localparam int          WORDS_PER_FRAME_DEF = 64;
  localparam logic [15:0] HEADER_DEF          = 16'hA5C3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: divides clk_27 into bit periods of CLK_DIV cycles.
// div_cnt restarts at 0 on a frame start and is held at 0 whenever the
// transmitter is not shifting, so SCLK idles low (mode 0).
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_27,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic spi_sclk,
  output logic bit_end,
  output logic pre_end
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             sclk_r;

  // Next divider value: cleared on start or when idle, wraps at CLK_DIV-1.
  always_comb begin
    div_nxt_s = '0;
    if (clr || !run) begin
      div_nxt_s = '0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_nxt_s = '0;
    end else begin
      div_nxt_s = div_cnt_r + DIV_W'(1);
    end
  end

  // Divider and SCLK registers; SCLK is high for the second half of each bit.
  always_ff @(posedge clk_27) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
      sclk_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      sclk_r    <= (div_nxt_s >= DIV_HALF);
    end
  end

  assign spi_sclk = sclk_r;
  assign bit_end  = (div_cnt_r == DIV_LAST);
  assign pre_end  = (div_cnt_r == DIV_PRE);

endmodule

// File: rtl/spi_frame_tx.sv
// SPI frame transmitter: on each rising edge of the delayed vsync, sends a
// header word followed by WORDS_PER_FRAME payload words pulled from a
// valid/ready source. Missing payload words are sent as zeros.
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int                CLK_DIV         = CLK_DIV_DEF,
  parameter int                WORD_W          = WORD_W_DEF,
  parameter int                WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
  parameter logic [WORD_W-1:0] HEADER          = WORD_W'(HEADER_DEF)
) (
  input  logic              clk_27,
  input  logic              rst_n,
  input  logic              vsync_d,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int            BC_W    = $clog2(WORD_W);
  localparam int            WC_W    = $clog2(WORDS_PER_FRAME + 1);
  localparam int            HC_W    = $clog2(CLK_DIV / 2) > 0 ? $clog2(CLK_DIV / 2) : 1;
  localparam logic [BC_W-1:0] BC_TOP  = BC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_FRAME);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV / 2 - 1);

  spi_state_e        state_r,    state_nxt;
  logic [WORD_W-1:0] shreg_r,    shreg_nxt;
  logic [BC_W-1:0]   bit_cnt_r,  bit_cnt_nxt;
  logic [WC_W-1:0]   word_cnt_r, word_cnt_nxt;
  logic [HC_W-1:0]   hold_cnt_r, hold_cnt_nxt;
  logic              mosi_r,     mosi_nxt;
  logic              cs_n_r,     cs_n_nxt;
  logic              busy_r,     busy_nxt;
  logic              ready_r,    ready_nxt;
  logic              done_r,     done_nxt;
  logic              under_r,    under_nxt;
  logic              vs_q_r;
  logic              start_s;
  logic              run_s;
  logic              bit_end_s;
  logic              pre_end_s;

  assign start_s = vsync_d & ~vs_q_r & (state_r == IDLE);
  assign run_s   = (state_nxt == XFER);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_27   (clk_27),
    .rst_n    (rst_n),
    .clr      (start_s),
    .run      (run_s),
    .spi_sclk (spi_sclk),
    .bit_end  (bit_end_s),
    .pre_end  (pre_end_s)
  );

  // Framing FSM: next state, shift register, counters and output values.
  always_comb begin
    state_nxt    = state_r;
    shreg_nxt    = shreg_r;
    bit_cnt_nxt  = bit_cnt_r;
    word_cnt_nxt = word_cnt_r;
    hold_cnt_nxt = hold_cnt_r;
    mosi_nxt     = mosi_r;
    cs_n_nxt     = cs_n_r;
    busy_nxt     = busy_r;
    ready_nxt    = 1'b0;
    done_nxt     = 1'b0;
    under_nxt    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt    = XFER;
          shreg_nxt    = HEADER;
          mosi_nxt     = HEADER[WORD_W-1];
          bit_cnt_nxt  = BC_TOP;
          word_cnt_nxt = '0;
          cs_n_nxt     = 1'b0;
          busy_nxt     = 1'b1;
        end else begin
          mosi_nxt = 1'b0;
          cs_n_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
      XFER: begin
        if (bit_end_s) begin
          if (bit_cnt_r != '0) begin
            shreg_nxt   = {shreg_r[WORD_W-2:0], 1'b0};
            mosi_nxt    = shreg_r[WORD_W-2];
            bit_cnt_nxt = bit_cnt_r - BC_W'(1);
          end else if (word_cnt_r != WC_LAST) begin
            // Payload word boundary: take the source word or fill with zeros.
            if (data_valid) begin
              shreg_nxt = data_in;
              mosi_nxt  = data_in[WORD_W-1];
            end else begin
              shreg_nxt = '0;
              mosi_nxt  = 1'b0;
              under_nxt = 1'b1;
            end
            bit_cnt_nxt  = BC_TOP;
            word_cnt_nxt = word_cnt_r + WC_W'(1);
          end else begin
            state_nxt    = HOLD;
            mosi_nxt     = 1'b0;
            hold_cnt_nxt = '0;
          end
        end else begin
          // Raise ready for the cycle on which the next word is captured.
          ready_nxt = pre_end_s && (bit_cnt_r == '0) && (word_cnt_r != WC_LAST);
        end
      end
      HOLD: begin
        if (hold_cnt_r == HC_LAST) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
          cs_n_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt_r + HC_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        mosi_nxt  = 1'b0;
        cs_n_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_27) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      bit_cnt_r  <= '0;
      word_cnt_r <= '0;
      hold_cnt_r <= '0;
      mosi_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
      done_r     <= 1'b0;
      under_r    <= 1'b0;
      vs_q_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      shreg_r    <= shreg_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      word_cnt_r <= word_cnt_nxt;
      hold_cnt_r <= hold_cnt_nxt;
      mosi_r     <= mosi_nxt;
      cs_n_r     <= cs_n_nxt;
      busy_r     <= busy_nxt;
      ready_r    <= ready_nxt;
      done_r     <= done_nxt;
      under_r    <= under_nxt;
      vs_q_r     <= vsync_d;
    end
  end

  assign spi_mosi   = mosi_r;
  assign spi_cs_n   = cs_n_r;
  assign busy       = busy_r;
  assign data_ready = ready_r;
  assign frame_done = done_r;
  assign underrun   = under_r;

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Downstream consumer of the delayed vsync (`vsync_o` of the vsync delay stage) in the clk_27 domain.
- On each rising edge of the delayed vsync, sends one SPI frame: a fixed header word followed by WORDS_PER_FRAME payload words.
- Payload words come from an upstream valid/ready source.
- SCLK is derived from clk_27 by an integer divider. With the default divider, one SPI bit equals the vsync delay length.

Parameters:
- CLK_DIV, 112: clk_27 cycles per SCLK period. Must be even and >= 4.
- WORD_W, 16: bits per SPI word, sent MSB first.
- WORDS_PER_FRAME, 64: payload words per frame, excluding the header. Must be >= 1.
- HEADER, 16'hA5C3: constant first word of every frame. Width is WORD_W.

Ports:
- clk_27  in  1  system clock, 27 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- vsync_d  in  1  delayed vsync from the delay stage.
- data_in  in  WORD_W  payload word.
- data_valid  in  1  data_in holds a valid word.
- data_ready  out  1  block captures data_in on this cycle.
- spi_sclk  out  1  SPI clock, mode 0, idles low.
- spi_mosi  out  1  SPI data out.
- spi_cs_n  out  1  chip select, active-low.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- underrun  out  1  one-cycle pulse when a payload word was not available.

Behaviour:
- Reset: while rst_n=0 at a clk_27 edge, on that edge:
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0;
  - data_ready=0, frame_done=0, underrun=0;
  - state goes to IDLE and all counters clear.
  - A reset mid-frame aborts the frame at once, with no frame_done.
- Edge detect:
  - vs_q <= vsync_d each cycle.
  - start = vsync_d & ~vs_q & (state==IDLE).
  - Rising edges while busy are ignored, with no queuing.
- States: IDLE, XFER, HOLD.
- IDLE to XFER, on the edge where start=1:
  - spi_cs_n goes low;
  - the shift register loads HEADER;
  - spi_mosi = HEADER[WORD_W-1];
  - busy goes to 1.
- XFER bit timing:
  - Each bit period is CLK_DIV cycles, counted by div_cnt from 0 to CLK_DIV-1.
  - spi_sclk=0 while div_cnt < CLK_DIV/2, and 1 otherwise.
  - The receiver samples on the rising edge.
  - The shift register shifts, and spi_mosi updates, on the edge where div_cnt wraps to 0. This coincides with the SCLK falling edge.
- Word sequence:
  - bit_cnt counts WORD_W-1 down to 0; word_cnt counts 0 to WORDS_PER_FRAME.
  - Word 0 is the header.
  - When bit_cnt==0, div_cnt==CLK_DIV-1, and more words remain: data_ready=1 for exactly that cycle.
  - On that edge the shift register loads data_in if data_valid=1.
  - If data_valid=0 it loads all-zeros and underrun pulses on the following cycle.
  - data_ready is 0 at all other times, including during the header load.
- Frame end: after the last bit period of word WORDS_PER_FRAME:
  - go to HOLD for CLK_DIV/2 cycles, with spi_sclk=0, spi_cs_n=0 and spi_mosi=0;
  - then spi_cs_n=1 and busy=0, frame_done=1 for one cycle, and return to IDLE.
- Frame length: spi_cs_n stays low for exactly (WORDS_PER_FRAME+1)*WORD_W*CLK_DIV + CLK_DIV/2 cycles.
- Back-to-back frames: a vsync edge arriving on the frame_done cycle is accepted, because the state is already IDLE.
- All outputs are registered.

Decomposition:
- Shared package spi_pkg holds:
  - the default values CLK_DIV_DEF=112, WORD_W_DEF=16, HEADER_DEF;
  - the state enum typedef.
- One natural sub-module: spi_clk_gen. It holds div_cnt and produces spi_sclk, a bit-end strobe (div_cnt==CLK_DIV-1), and a sync clear on start/reset.
- Shifting and framing stay in spi_frame_tx.

Test Plan (CLK_DIV=4, WORD_W=8, WORDS_PER_FRAME=2, HEADER=8'hA5):
- Reset is held for 5 cycles, then vsync_d=0 -> spi_cs_n=1, spi_sclk=0, busy=0, and no pulses.
- vsync_d rises, with the source always valid and supplying 8'h3C then 8'hF0:
  - spi_cs_n goes low 1 cycle after the edge and stays low for 98 cycles;
  - MOSI sampled on SCLK rising edges reads A5, 3C, F0;
  - there are 24 SCLK rising edges;
  - frame_done pulses once; underrun never pulses.
- Source deasserts data_valid for the second word -> the bytes read A5, 3C, 00; underrun pulses exactly once; frame length is unchanged.
- A second vsync_d rising edge 20 cycles into a frame -> it is ignored, and exactly one frame_done occurs.
- rst_n is driven low at cycle 40 of a frame -> on the next edge spi_cs_n=1, spi_sclk=0, busy=0, and no frame_done. A fresh vsync edge afterwards produces a complete 98-cycle frame.
- vsync_d rises in the frame_done cycle -> a new frame starts on the next cycle (spi_cs_n goes low again after exactly one high cycle).
